// File: rtl/sobel_obi_reader.sv
// sobel_obi_reader: fetches a run of 32-bit words from memory over OBI, one transaction
// at a time, and streams each word out as four 8-bit pixels, byte 0 first.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   start_i                   one-cycle pulse launching a job (ignored unless idle)
//   base_addr_i, num_words_i  job start address and word count, sampled at start
//   busy_o, done_o, err_o     job active, one-cycle completion pulse, sticky bus error
//   req_o .. wdata_o, gnt_i   OBI A channel (manager side, read-only use)
//   rvalid_i, rdata_i, err_i  OBI R channel
//   pix_*                     pixel stream to the edge-magnitude stage
module sobel_obi_reader #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [CntWidth-1:0]  num_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 we_o,
    output logic [3:0]           be_o,
    output logic [DataWidth-1:0] wdata_o,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    input  logic                 err_i,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic [7:0]           pix_data_o,
    output logic                 pix_last_o
);

    typedef enum logic [2:0] {StIdle, StReq, StWaitR, StStream, StDone} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q;
    logic [CntWidth-1:0]   remaining_q;
    logic [DataWidth-1:0]  word_q;
    logic [1:0]            idx_q;
    logic                  err_q;
    logic                  done_q;
    logic                  pix_fire;

    assign pix_fire = (state_q == StStream) && pix_ready_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (num_words_i != '0) ? StReq : StDone;
                end
            end
            StReq: begin
                if (gnt_i) begin
                    state_d = StWaitR;
                end
            end
            StWaitR: begin
                if (rvalid_i) begin
                    state_d = err_i ? StDone : StStream;
                end
            end
            StStream: begin
                if (pix_fire && (idx_q == 2'd3)) begin
                    // remaining_q is the count before this word retires
                    state_d = (remaining_q == CntWidth'(1)) ? StDone : StReq;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_o       = 1'b0;
        busy_o      = 1'b1;
        pix_valid_o = 1'b0;
        pix_last_o  = 1'b0;
        unique case (state_q)
            StIdle:   busy_o = 1'b0;
            StReq:    req_o = 1'b1;
            StStream: begin
                pix_valid_o = 1'b1;
                pix_last_o  = (idx_q == 2'd3) && (remaining_q == CntWidth'(1));
            end
            default: ;
        endcase
    end

    assign addr_o     = addr_q;
    assign pix_data_o = word_q[{idx_q, 3'b000} +: 8];
    assign err_o      = err_q;
    // Pulse lands the cycle after DONE, i.e. two cycles after start for an empty job
    assign done_o     = done_q;
    assign we_o       = 1'b0;
    assign be_o       = 4'hF;
    assign wdata_o    = '0;

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        addr_q      <= {base_addr_i[AddrWidth-1:2], 2'b00};
                        remaining_q <= num_words_i;
                        err_q       <= 1'b0;
                    end
                end
                StWaitR: begin
                    if (rvalid_i) begin
                        if (err_i) begin
                            err_q <= 1'b1;
                        end else begin
                            word_q <= rdata_i;
                            idx_q  <= '0;
                        end
                    end
                end
                StStream: begin
                    if (pix_fire) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            remaining_q <= remaining_q - CntWidth'(1);
                            addr_q      <= addr_q + AddrWidth'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_obi_reader.sv
// Bench for sobel_obi_reader: directed scenarios plus randomized jobs, checked against a
// job-level model (expected address list and pixel list built from a memory image).
module tb_sobel_obi_reader;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] num_words_i;
    logic        busy_o, done_o, err_o;
    logic        req_o, gnt_i, we_o;
    logic [31:0] addr_o, wdata_o, rdata_i;
    logic [3:0]  be_o;
    logic        rvalid_i, err_i;
    logic        pix_valid_o, pix_ready_i, pix_last_o;
    logic [7:0]  pix_data_o;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    sobel_obi_reader #(
        .AddrWidth(32),
        .DataWidth(32),
        .CntWidth (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .num_words_i(num_words_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .be_o       (be_o),
        .wdata_o    (wdata_o),
        .rvalid_i   (rvalid_i),
        .rdata_i    (rdata_i),
        .err_i      (err_i),
        .pix_valid_o(pix_valid_o),
        .pix_ready_i(pix_ready_i),
        .pix_data_o (pix_data_o),
        .pix_last_o (pix_last_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {63'd0, req_o}, 64'd0);
        check({tag, "_pv"},    {63'd0, pix_valid_o}, 64'd0);
        check({tag, "_plast"}, {63'd0, pix_last_o}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy_o}, 64'd0);
        check({tag, "_done"},  {63'd0, done_o}, 64'd0);
        check({tag, "_err"},   {63'd0, err_o}, 64'd0);
        check({tag, "_addr"},  {32'd0, addr_o}, 64'd0);
        check({tag, "_pdata"}, {56'd0, pix_data_o}, 64'd0);
    endtask

    // One job. err_at: index of the word that returns a bus error (-1 none).
    // abort_at > 0: assert reset at that observation (after a start pulse two cycles earlier).
    task automatic run_job(input logic [31:0] base, input int n, input int gnt_delay,
                           input bit rand_ready, input int err_at, input int abort_at);
        logic [31:0] exp_addr[$];
        logic [7:0]  exp_pix[$];
        logic [31:0] a, gaddr;
        int          exp_reqs, nreq, npix, obs, gwait, gerr_idx;
        bit          exp_err, done_seen, granted, req_prev, first_pix;

        exp_err  = (err_at >= 0) && (err_at < n);
        exp_reqs = exp_err ? err_at + 1 : n;
        for (int w = 0; w < exp_reqs; w++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * w);
            exp_addr.push_back(a);
            if (!(exp_err && w == err_at))
                for (int b = 0; b < 4; b++) exp_pix.push_back(8'(mem_rd(a) >> (8 * b)));
        end
        nreq = 0; npix = 0; obs = 0; gwait = 0; gerr_idx = 0; gaddr = '0;
        done_seen = 0; granted = 0; req_prev = 0; first_pix = 0;

        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; num_words_i = 16'(n);
        gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; pix_ready_i = 1'b0;

        while (!done_seen && obs < 400) begin
            @(negedge clk);
            obs++;
            start_i = 1'b0;
            if (abort_at > 0 && obs == abort_at) begin
                rst_i = 1'b1;
                #1;
                check_all_zero("abort");
                return;
            end
            // Observe
            if (obs == 1) check("err_clr_on_start", {63'd0, err_o}, 64'd0);
            check("const_we_be_wd", {27'd0, we_o, be_o, wdata_o}, {27'd0, 1'b0, 4'hF, 32'd0});
            if (req_o) begin
                if (nreq < exp_reqs) check("addr", {32'd0, addr_o}, {32'd0, exp_addr[nreq]});
                else check("extra_req", 64'd1, 64'd0);
            end
            if (pix_valid_o) begin
                if (!first_pix) begin
                    first_pix = 1;
                    check("first_pix_lat", 64'(obs), 64'(3 + gnt_delay));
                end
                if (npix < exp_pix.size()) begin
                    check("pix_data", {56'd0, pix_data_o}, {56'd0, exp_pix[npix]});
                    check("pix_last", {63'd0, pix_last_o},
                          {63'd0, (npix == exp_pix.size() - 1) && !exp_err});
                end else begin
                    check("extra_pix", 64'd1, 64'd0);
                end
            end
            if (done_o) begin
                done_seen = 1;
                check("done_npix", 64'(npix), 64'(exp_pix.size()));
                check("done_nreq", 64'(nreq), 64'(exp_reqs));
                check("done_err", {63'd0, err_o}, {63'd0, exp_err});
                check("done_busy", {63'd0, busy_o}, 64'd0);
                if (n == 0) check("empty_done_lat", 64'(obs), 64'd2);
            end else begin
                check("busy", {63'd0, busy_o}, 64'd1);
            end
            // Drive
            rvalid_i = 1'b0; err_i = 1'b0; rdata_i = $urandom; gnt_i = 1'b0;
            if (granted) begin
                rvalid_i = 1'b1;
                rdata_i  = mem_rd(gaddr);
                err_i    = (gerr_idx == err_at);
                granted  = 0;
            end else if (pix_valid_o && $urandom_range(0, 2) == 0) begin
                rvalid_i = 1'b1;   // stray response, must be ignored
                err_i    = 1'($urandom_range(0, 1));
            end
            if (req_o) begin
                if (!req_prev) gwait = gnt_delay;
                if (gwait == 0) begin
                    gnt_i    = 1'b1;
                    granted  = 1;
                    gerr_idx = nreq;
                    gaddr    = (nreq < exp_reqs) ? exp_addr[nreq] : 32'd0;
                    nreq++;
                end else begin
                    gwait--;
                end
            end else if (pix_valid_o && $urandom_range(0, 2) == 0) begin
                gnt_i = 1'b1;      // stray grant, must be ignored
            end
            req_prev = req_o;
            if (pix_valid_o) begin
                pix_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pix_ready_i) npix++;
            end else begin
                pix_ready_i = 1'($urandom_range(0, 1));
            end
            if (abort_at > 0 && obs == abort_at - 2) begin
                start_i = 1'b1; base_addr_i = 32'hDEAD_0000; num_words_i = 16'd0;
            end
        end
        if (!done_seen) check("timeout", 64'd0, 64'd1);
        gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; pix_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("done_single", {63'd0, done_o}, 64'd0);
            check("idle_busy", {63'd0, busy_o}, 64'd0);
            check("err_sticky", {63'd0, err_o}, {63'd0, exp_err});
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0; pix_ready_i = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        mem[32'h1000] = 32'h4433_2211;
        mem[32'h1004] = 32'h8877_6655;
        run_job(32'h0000_1000, 2, 0, 0, -1, 0);          // basic two-word job
        run_job(32'h0000_2000, 0, 0, 0, -1, 0);          // empty job
        run_job(32'h0000_3000, 3, 5, 1, -1, 0);          // slow grant, random ready
        run_job(32'h0000_4000, 3, 0, 0, 1, 0);           // bus error on word 1
        run_job(32'h0000_5000, 1, 0, 0, -1, 0);          // err_o must clear here
        run_job(32'hFFFF_FFFE, 2, 1, 0, -1, 0);          // address wrap

        // Abort during STREAM of word 1, with an ignored start two cycles earlier
        run_job(32'h0000_6000, 3, 0, 0, -1, 10);
        @(negedge clk);
        check_all_zero("in_reset");
        rst_i = 1'b0;
        run_job(32'h0000_7000, 2, 0, 0, -1, 0);

        for (int j = 0; j < 10; j++) begin
            int n;
            int e;
            n = $urandom_range(1, 4);
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_job($urandom, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), e, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sobel_obi_reader.md
SOBEL_OBI_READER -- requirements
Module: sobel_obi_reader

Interface
REQ-001 Parameter AddrWidth, default 32, SHALL set the OBI address width.
REQ-002 Parameter DataWidth, default 32, SHALL set the OBI data width; only 32 is supported.
REQ-003 Parameter CntWidth, default 16, SHALL set the word-count width.
REQ-004 clk_i  in  1  SHALL be the single clock; all flops are rising-edge.
REQ-005 rst_i  in  1  SHALL be the reset, asynchronous and active-high.
REQ-006 start_i  in  1  SHALL be a one-cycle pulse that launches a read job.
REQ-007 base_addr_i  in  AddrWidth  SHALL be the job start address, sampled at start.
REQ-008 num_words_i  in  CntWidth  SHALL be the 32-bit word count, sampled at start.
REQ-009 busy_o  out  1  SHALL be high while a job is active.
REQ-010 done_o  out  1  SHALL be a one-cycle job-completion pulse.
REQ-011 err_o  out  1  SHALL be a sticky bus-error flag.
REQ-012 req_o / gnt_i / addr_o[AddrWidth] / we_o / be_o[4] / wdata_o[32] SHALL form the OBI A channel, manager side.
REQ-013 rvalid_i / rdata_i[32] / err_i SHALL form the OBI R channel.
REQ-014 pix_valid_o / pix_ready_i / pix_data_o[8] / pix_last_o SHALL form the pixel output stream to the edge-magnitude stage.

Function
REQ-015 The block SHALL drive we_o=0, be_o=4'hF and wdata_o=0 constantly.
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT_R, STREAM and DONE.
REQ-017 IDLE: on start_i, latch base_addr_i with bits[1:0] forced to 0, and latch num_words_i; go to REQ if the count is nonzero, else go to DONE.
REQ-018 REQ: req_o=1, with addr_o = current address; hold req_o and addr_o stable until gnt_i; on gnt_i go to WAIT_R.
REQ-019 Only one transaction SHALL be outstanding; req_o=0 in every state except REQ.
REQ-020 WAIT_R: on rvalid_i with err_i=0, capture rdata_i into the word buffer, clear the byte index and go to STREAM.
REQ-021 WAIT_R: on rvalid_i with err_i=1, set err_o, discard the data and go to DONE.
REQ-022 STREAM: pix_valid_o=1; pix_data_o SHALL be word byte[idx], little-endian, so byte 0 (bits 7:0) is emitted first.
REQ-023 The stream SHALL hold pix_data_o and pix_last_o stable while pix_valid_o=1 and pix_ready_i=0.
REQ-024 A pixel SHALL transfer only when pix_valid_o and pix_ready_i are both high; idx then increments.
REQ-025 On transfer of byte 3: the remaining count decrements and the address increments by 4 modulo 2^AddrWidth; go to REQ if the remaining count is nonzero, else go to DONE.
REQ-026 pix_last_o SHALL be 1 only on byte 3 of the final word.
REQ-027 DONE: done_o=1 for exactly one cycle, then return to IDLE.
REQ-028 busy_o SHALL be 1 in REQ, WAIT_R, STREAM and DONE.
REQ-029 start_i SHALL be ignored outside IDLE.
REQ-030 err_o SHALL clear on an accepted start_i; otherwise it holds until reset.
REQ-031 rvalid_i outside WAIT_R SHALL be ignored.
REQ-032 gnt_i outside REQ SHALL be ignored.
REQ-033 Minimum latency: first pixel valid 3 cycles after start when gnt_i is same-cycle and rvalid_i arrives the cycle after grant.
REQ-034 Best-case throughput: 1 word per 6 cycles (REQ, WAIT_R, 4x STREAM).

Reset
REQ-035 While rst_i=1: state=IDLE; req_o, pix_valid_o, pix_last_o, busy_o, done_o and err_o = 0; addr_o, pix_data_o and internal registers = 0.
REQ-036 Assertion of rst_i mid-job SHALL abort the job immediately, with no done_o pulse.
REQ-037 After rst_i deasserts, the block SHALL accept start_i on the next edge.

Verification
REQ-038 Scenario: base=0x1000, n=2, memory {0x44332211, 0x88776655}, gnt_i and pix_ready_i always 1 -> addresses 0x1000 then 0x1004; pixels 11,22,33,44,55,66,77,88; pix_last_o on 88; one done_o pulse; err_o=0.
REQ-039 Scenario: n=0 -> no req_o; done_o exactly 2 cycles after start; no pixels.
REQ-040 Scenario: gnt_i delayed 5 cycles and pix_ready_i toggling randomly -> addr_o and pix_data_o stable while stalled; pixel order and count unchanged.
REQ-041 Scenario: err_i=1 on word 1 of a 3-word job -> err_o=1; 4 pixels emitted; no further req_o; done_o pulse; err_o cleared by the next start.
REQ-042 Scenario: base=0xFFFFFFFE, n=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-043 Scenario: rst_i asserted during STREAM and start_i pulsed while busy -> all outputs 0 immediately; the start during busy is ignored.
